uart_byte_tx: RTL and testbench
===============================

Name: uart_byte_tx

Overview:
- Byte-oriented UART transmitter; the transmit counterpart of the board UART receive path under `top`.
- Accepts bytes from the core logic over a valid/ready handshake and serialises them onto `o_uart_tx`.
- Frame format: 8N1 by default, LSB first, idle-high line, 115200 baud from the 25 MHz system clock.
- Has a one-entry holding register, so back-to-back bytes go out with no idle gap.

Parameters:
- CLK_FREQ, 25000000: system clock frequency in Hz.
- BAUD, 115200: line rate in bit/s.
- DIVISOR, round(CLK_FREQ/BAUD) = 217: clocks per bit. Derived; not overridden directly.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.

Ports:
- i_clk  in  1  system clock. One clock; reset is synchronous and active-high.
- i_rst  in  1  synchronous active-high reset, sampled on rising i_clk.
- i_tx_dat  in  8  byte to send, qualified by i_tx_en.
- i_tx_en  in  1  byte valid; the byte is accepted on the rising edge where i_tx_en && o_tx_ready.
- o_tx_ready  out  1  holding register empty; the block can accept a byte.
- o_uart_tx  out  1  serial line, registered output, idle 1.
- o_busy  out  1  a frame is on the line (any state other than IDLE).
- o_tx_done  out  1  one-cycle pulse in the last clock of the final stop bit.

Behaviour:
- Reset values: o_uart_tx = 1, o_tx_ready = 1, o_busy = 0, o_tx_done = 0. Holding register is emptied, baud counter = 0, state = IDLE.
- Reset mid-frame aborts the frame. The line returns to 1 on the edge after reset is sampled, and the pending byte is discarded.
- Accept rule: if i_tx_en && o_tx_ready at edge k, the byte is latched into the holding register and o_tx_ready = 0 from k+1. i_tx_en while o_tx_ready = 0 is ignored and the data is dropped.
- Latency: when IDLE and a byte is accepted at edge k, the byte moves to the shift register and o_uart_tx = 0 (start bit) from edge k+1. o_tx_ready returns to 1 at k+2 because the holding register is freed at k+1.
- States: IDLE -> START -> DATA -> PARITY (only if PARITY != 0) -> STOP -> IDLE, or directly to START if the holding register is full.
- Bit duration: exactly DIVISOR clocks per bit, counted by the baud counter 0..DIVISOR-1. A state or bit advances when the counter reaches DIVISOR-1, and the counter then wraps to 0.
- DATA: LSB first. A 3-bit index runs 0..7, and the state exits after index 7 completes.
- Parity bit: XOR of the 8 data bits for even parity, inverted for odd parity.
- STOP: lasts STOP_BITS*DIVISOR clocks at line level 1.
- o_tx_done is asserted in the final clock of STOP.
- Back-to-back: if the holding register is full at the final STOP clock, the next edge enters START with no idle cycle and the holding register is freed.
- Frame length: DIVISOR*(9 + (PARITY != 0) + STOP_BITS) clocks, i.e. 2170 clocks (86.8 us) at the defaults.
- Simultaneous accept and holding-register transfer in the same cycle cannot occur, because o_tx_ready = 0 whenever the register is full.
- o_busy = 1 in all states except IDLE.
- All outputs are registered; there is no combinational path from the inputs to the outputs.

Decomposition:
- Shared package `uart_pkg` holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - the parity encoding constants;
  - the DIVISOR derivation function, shared with the receiver so both ends agree on bit timing.
- Sub-module `uart_baud_cnt`:
  - a counter with clear and a one-cycle tick at DIVISOR-1;
  - also reused by the receiver's half-bit sampler.

Test Plan:
- Single byte: reset for 25 cycles, then send 0x5A with one-cycle i_tx_en. Required response:
  - start bit at the next edge;
  - line sequence 0,0,1,0,1,1,0,1,0,1, each level held 217 clocks (8680 ns);
  - o_tx_done pulses once, 2170 clocks after the start bit began.
- Back-to-back: send 0xA5, then 0x3C as soon as o_tx_ready rises. Required response:
  - the stop bit of 0xA5 is followed immediately by the start bit of 0x3C, with zero idle clocks;
  - total on-line time is 4340 clocks.
- Overrun: assert i_tx_en with 0xFF while o_tx_ready = 0. Required response: only the previously accepted bytes appear on the line, and 0xFF is never transmitted.
- Parity and stop bits: set PARITY = 2, STOP_BITS = 2 and send 0x07. Required response:
  - data bits 1,1,1,0,0,0,0,0;
  - parity bit 1;
  - two stop bits;
  - frame length 217*12 = 2604 clocks.
- Reset mid-frame: assert i_rst during data bit 3 of 0x00. Required response:
  - o_uart_tx = 1 at the next edge; o_busy = 0, o_tx_ready = 1;
  - no o_tx_done pulse;
  - a new byte sent afterwards produces a clean frame.
- Loopback: connect o_uart_tx to the existing receiver in `top`, send 0x00, 0xFF and 0x55. Required response: the receiver reports each byte exactly, in order.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity selection
// constants and the bit-timing divisor used by both transmit and receive.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  // Clocks per bit, rounded to nearest so both ends land on the same value.
  function automatic int unsigned calc_divisor(input int unsigned clk_freq,
                                               input int unsigned baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: runs 0..DIV-1 and wraps, with a one-cycle tick on the
// last count. Held at zero while clr is asserted.
module uart_baud_cnt #(
  parameter int unsigned DIV = 217,
  parameter int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          tick
);

  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  assign tick = (cnt == LAST);

  // Count clocks within the current bit, wrapping on the tick.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_byte_tx.sv
// Byte UART transmitter with a one-entry holding register so consecutive
// bytes leave with no idle gap. Frame: start, 8 data LSB first, optional
// parity, 1 or 2 stop bits. All outputs come straight from flops.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 25000000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_tx_dat,
  input  logic       i_tx_en,
  output logic       o_tx_ready,
  output logic       o_uart_tx,
  output logic       o_busy,
  output logic       o_tx_done
);

  localparam int unsigned DIVISOR = calc_divisor(CLK_FREQ, BAUD);
  localparam int unsigned CW      = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CW-1:0] CNT_PRE   = CW'(DIVISOR - 2);
  localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);

  tx_state_e       state, state_n;
  logic [7:0]      shreg, shreg_n;
  logic [2:0]      idx, idx_n;
  logic            par_q, par_n;
  logic [7:0]      hold_dat, hold_dat_n;
  logic            hold_full, hold_full_n;
  logic            ready_n, tx_n, busy_n, done_n;
  logic            accept, load;
  logic [CW-1:0]   cnt;
  logic            tick;

  uart_baud_cnt #(.DIV(DIVISOR), .CW(CW)) u_baud (
    .clk  (i_clk),
    .rst  (i_rst),
    .clr  (state == ST_IDLE),
    .cnt  (cnt),
    .tick (tick)
  );

  // Next-state, holding-register and registered-output decode.
  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    idx_n       = idx;
    par_n       = par_q;
    hold_dat_n  = hold_dat;
    hold_full_n = hold_full;
    load        = 1'b0;
    accept      = i_tx_en && o_tx_ready;

    unique case (state)
      ST_IDLE: begin
        if (hold_full) load = 1'b1;
      end
      ST_START: begin
        if (tick) begin
          state_n = ST_DATA;
          idx_n   = '0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (idx == 3'd7) begin
            state_n = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            idx_n   = '0;
          end else begin
            idx_n   = idx + 3'd1;
            shreg_n = shreg >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_n = ST_STOP;
          idx_n   = '0;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (idx == LAST_STOP) begin
            if (hold_full) load = 1'b1;
            else           state_n = ST_IDLE;
          end else begin
            idx_n = idx + 3'd1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (load) begin
      state_n     = ST_START;
      shreg_n     = hold_dat;
      par_n       = (^hold_dat) ^ (PARITY == PAR_ODD);
      hold_full_n = 1'b0;
    end

    if (accept) begin
      hold_dat_n  = i_tx_dat;
      hold_full_n = 1'b1;
    end

    // Ready follows the holding register one clock late, so a byte freed
    // into the shifter re-opens the handshake on the following edge.
    ready_n = accept ? 1'b0 : !hold_full;

    unique case (state_n)
      ST_START:  tx_n = 1'b0;
      ST_DATA:   tx_n = shreg_n[0];
      ST_PARITY: tx_n = par_n;
      default:   tx_n = 1'b1;
    endcase

    busy_n = (state_n != ST_IDLE);
    // Registered one clock early so the pulse lands in the final stop clock.
    done_n = (state == ST_STOP) && (cnt == CNT_PRE) && (idx == LAST_STOP);
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      idx        <= '0;
      par_q      <= 1'b0;
      hold_dat   <= '0;
      hold_full  <= 1'b0;
      o_tx_ready <= 1'b1;
      o_uart_tx  <= 1'b1;
      o_busy     <= 1'b0;
      o_tx_done  <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      idx        <= idx_n;
      par_q      <= par_n;
      hold_dat   <= hold_dat_n;
      hold_full  <= hold_full_n;
      o_tx_ready <= ready_n;
      o_uart_tx  <= tx_n;
      o_busy     <= busy_n;
      o_tx_done  <= done_n;
    end
  end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Directed bench for uart_byte_tx: default 8N1 instance plus an 8E2 instance.
module tb_uart_byte_tx;

  localparam int unsigned D = 217;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic       rst;
  logic [7:0] dat, dat_p;
  logic       en, en_p;
  logic       ready, tx, busy, done;
  logic       ready_p, tx_p, busy_p, done_p;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic rec   = 1'b0;
  logic rec_p = 1'b0;
  logic l0[$], d0[$], lp[$], dp[$];

  uart_byte_tx dut (
    .i_clk(clk), .i_rst(rst), .i_tx_dat(dat), .i_tx_en(en),
    .o_tx_ready(ready), .o_uart_tx(tx), .o_busy(busy), .o_tx_done(done)
  );

  uart_byte_tx #(.PARITY(2), .STOP_BITS(2)) dut_p (
    .i_clk(clk), .i_rst(rst), .i_tx_dat(dat_p), .i_tx_en(en_p),
    .o_tx_ready(ready_p), .o_uart_tx(tx_p), .o_busy(busy_p), .o_tx_done(done_p)
  );

  // Line recorder, one sample per clock just after the rising edge.
  always @(posedge clk) begin
    #1;
    if (rec)   begin l0.push_back(tx);   d0.push_back(done);   end
    if (rec_p) begin lp.push_back(tx_p); dp.push_back(done_p); end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned qsize(input bit sel);
    return sel ? lp.size() : l0.size();
  endfunction
  function automatic logic qline(input bit sel, input int unsigned i);
    return sel ? lp[i] : l0[i];
  endfunction
  function automatic logic qdone(input bit sel, input int unsigned i);
    return sel ? dp[i] : d0[i];
  endfunction

  task automatic send(input bit sel, input logic [7:0] b);
    if (sel) begin dat_p = b; en_p = 1'b1; end
    else     begin dat   = b; en   = 1'b1; end
    @(negedge clk);
    en = 1'b0; en_p = 1'b0;
  endtask

  task automatic wait_ready(input bit sel, input string tag);
    int unsigned n = 0;
    while (!(sel ? ready_p : ready) && n < 10000) begin
      @(negedge clk); n++;
    end
    check({tag, " ready within budget"}, sel ? ready_p : ready, 1);
  endtask

  task automatic wait_idle(input bit sel, input string tag);
    int unsigned n = 0;
    @(negedge clk);
    while ((sel ? busy_p : busy) && n < 10000) begin
      @(negedge clk); n++;
    end
    check({tag, " idle within budget"}, sel ? busy_p : busy, 0);
  endtask

  // Compare the recorded line against expected levels (index 0 = start bit),
  // each held D clocks; everything after the frame must stay at 1.
  task automatic verify(input string tag, input bit sel, input logic [63:0] lv,
                        input int unsigned nbits, input int unsigned ndone,
                        input int unsigned last_done);
    int unsigned s = 0, bad = 0, dn = 0, dpos = 0;
    logic found = 1'b0;
    for (int unsigned i = 0; i < qsize(sel); i++)
      if (!found && qline(sel, i) == 1'b0) begin s = i; found = 1'b1; end
    check({tag, " start found"}, found, 1);
    if (!found) return;
    for (int unsigned c = 0; c < nbits * D; c++)
      if (s + c >= qsize(sel) || qline(sel, s + c) !== lv[c / D]) bad++;
    for (int unsigned i = s + nbits * D; i < qsize(sel); i++)
      if (qline(sel, i) !== 1'b1) bad++;
    for (int unsigned i = 0; i < qsize(sel); i++)
      if (qdone(sel, i)) begin dn++; dpos = i - s; end
    check({tag, " line levels bad clocks"}, bad, 0);
    check({tag, " done pulse count"}, dn, ndone);
    check({tag, " last done offset"}, dpos, last_done);
  endtask

  initial begin
    logic [7:0] got[$];
    logic [7:0] exp_lb[3];
    logic [7:0] b;
    int unsigned i, dn, stop_bad;

    rst = 1'b1; en = 1'b0; en_p = 1'b0; dat = '0; dat_p = '0;
    repeat (25) @(negedge clk);
    check("reset uart_tx", tx, 1);
    check("reset tx_ready", ready, 1);
    check("reset busy", busy, 0);
    check("reset tx_done", done, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single byte 0x5A.
    rec = 1'b1;
    send(0, 8'h5A);
    check("line idle before start", tx, 1);
    check("ready low after accept", ready, 0);
    @(negedge clk);
    check("start bit at next edge", tx, 0);
    check("busy during frame", busy, 1);
    wait_idle(0, "single");
    repeat (5) @(negedge clk);
    rec = 1'b0;
    verify("single 5A", 0, 64'(10'b1010110100), 10, 1, 10 * D - 1);
    check("ready after single", ready, 1);
    l0.delete(); d0.delete();

    // Back-to-back 0xA5 then 0x3C, with 0xFF offered while full.
    rec = 1'b1;
    send(0, 8'hA5);
    wait_ready(0, "b2b");
    send(0, 8'h3C);
    check("ready low after second accept", ready, 0);
    dat = 8'hFF; en = 1'b1;
    repeat (60) @(negedge clk);
    check("ready low during overrun", ready, 0);
    en = 1'b0;
    wait_idle(0, "b2b");
    repeat (5) @(negedge clk);
    rec = 1'b0;
    verify("b2b A5 3C", 0, 64'({10'b1001111000, 10'b1101001010}), 20, 2, 20 * D - 1);
    l0.delete(); d0.delete();

    // Even parity, two stop bits, 0x07.
    rec_p = 1'b1;
    send(1, 8'h07);
    wait_idle(1, "parity");
    repeat (5) @(negedge clk);
    rec_p = 1'b0;
    verify("8E2 07", 1, 64'(12'b111000001110), 12, 1, 12 * D - 1);

    // Reset during data bit 3 of 0x00.
    rec = 1'b1;
    send(0, 8'h00);
    @(negedge clk);
    repeat (4 * D + 100) @(negedge clk);
    check("line low in data bit 3", tx, 0);
    check("busy in data bit 3", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort uart_tx", tx, 1);
    check("abort busy", busy, 0);
    check("abort tx_ready", ready, 1);
    rst = 1'b0;
    repeat (2500) @(negedge clk);
    rec = 1'b0;
    dn = 0;
    foreach (d0[k]) if (d0[k]) dn++;
    check("abort no done pulse", dn, 0);
    check("abort stays idle", busy, 0);
    l0.delete(); d0.delete();

    rec = 1'b1;
    send(0, 8'h81);
    wait_idle(0, "post-reset");
    repeat (5) @(negedge clk);
    rec = 1'b0;
    verify("post-reset 81", 0, 64'(10'b1100000010), 10, 1, 10 * D - 1);
    l0.delete(); d0.delete();

    // Loopback-style decode of 0x00, 0xFF, 0x55 sampled mid-bit.
    exp_lb[0] = 8'h00; exp_lb[1] = 8'hFF; exp_lb[2] = 8'h55;
    rec = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_ready(0, "loopback");
      send(0, exp_lb[k]);
    end
    wait_idle(0, "loopback");
    repeat (5) @(negedge clk);
    rec = 1'b0;
    i = 0; stop_bad = 0;
    while (i + 10 * D <= l0.size()) begin
      if (l0[i] == 1'b0) begin
        for (int k = 0; k < 8; k++) b[k] = l0[i + D * (k + 1) + D / 2];
        if (l0[i + 9 * D + D / 2] !== 1'b1) stop_bad++;
        got.push_back(b);
        i = i + 9 * D + D / 2 + 1;
      end else begin
        i++;
      end
    end
    check("loopback frame count", got.size(), 3);
    check("loopback stop bits", stop_bad, 0);
    for (int k = 0; k < 3; k++)
      check($sformatf("loopback byte %0d", k), (k < got.size()) ? got[k] : 8'hxx, exp_lb[k]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
